pmem_loader: RTL

- Program-memory responder for the fetch stage. It answers fetch addresses with instruction words at a fixed 1-cycle latency.
- It owns the instruction RAM. A byte-serial boot loader fills that RAM before the core runs.
- While loading, it holds the core in stall and returns NOP words.
- Sits between the fetch stage's pmem address/instruction pins and the boot byte source (UART receiver).

---
 rtl/swt16_pmem_pkg.sv | 21 ++
 rtl/pmem_ram.sv | 23 ++
 rtl/pmem_loader.sv | 120 ++++++++++++
 3 files changed

// File: rtl/swt16_pmem_pkg.sv
// Shared types and sizing helpers for the program-memory loader.
// Imported by the loader top; the RAM sub-module stays type-agnostic.
package swt16_pmem_pkg;

  localparam int LD_BYTE_W = 8;
  localparam int LEN_W     = 16;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    RUN     = 3'd4
  } ld_state_e;

  // One instruction word covers two byte addresses.
  function automatic int mem_depth(input int pc_width);
    return 1 << (pc_width - 1);
  endfunction

endpackage

// File: rtl/pmem_ram.sv
// Instruction RAM: one synchronous write port, one synchronous read port.
module pmem_ram #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // NOTE: the array and its read register have no reset so the tools can map them onto block RAM.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata      <= mem[raddr];
  end

endmodule

// File: rtl/pmem_loader.sv
// Program-memory responder with a byte-serial boot loader in front of it.
// Holds the core stalled and returns NOPs until a length-prefixed image is loaded.
module pmem_loader
  import swt16_pmem_pkg::*;
#(
  parameter int PC_WIDTH   = 12,
  parameter int PMEM_WIDTH = 16,
  parameter int BOOT_LOAD  = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [PC_WIDTH-1:0]  in_pmem_addr,
  output logic [PMEM_WIDTH-1:0] out_instr,
  output logic                 out_addr_misaligned,
  input  logic                 in_ld_valid,
  input  logic [LD_BYTE_W-1:0] in_ld_byte,
  output logic                 out_ld_ready,
  input  logic                 in_ld_restart,
  output logic                 out_core_stall,
  output logic                 out_load_done,
  output logic                 out_load_err
);

  localparam int             AW          = PC_WIDTH - 1;
  localparam int             MEM_DEPTH   = mem_depth(PC_WIDTH);
  localparam logic [LEN_W:0] DEPTH_L     = (LEN_W + 1)'(MEM_DEPTH);
  localparam ld_state_e      RESET_STATE = (BOOT_LOAD != 0) ? LEN_HI : RUN;

  ld_state_e              state_q, state_d;
  logic [LEN_W-1:0]       len_q, wcnt_q, wcnt_inc;
  logic [LD_BYTE_W-1:0]   hi_q;
  logic                   done_q, err_q, rd_en_q;
  logic                   accept, in_range, ram_we, ram_re, finish;
  logic [PMEM_WIDTH-1:0]  ram_rdata;

  assign out_ld_ready   = (state_q != RUN);
  assign out_core_stall = (state_q != RUN);
  assign accept         = in_ld_valid && out_ld_ready;
  assign wcnt_inc       = wcnt_q + 1'b1;
  assign in_range       = {1'b0, wcnt_q} < DEPTH_L;
  assign ram_re         = (state_q == RUN);
  assign finish         = (state_q != RUN) && (state_d == RUN);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    ram_we  = 1'b0;
    case (state_q)
      LEN_HI:  if (accept) state_d = LEN_LO;
      LEN_LO:  if (accept) state_d = ({len_q[15:8], in_ld_byte} == '0) ? RUN : DATA_HI;
      DATA_HI: if (accept) state_d = DATA_LO;
      DATA_LO: begin
        if (accept) begin
          ram_we  = in_range;
          state_d = (wcnt_inc == len_q) ? RUN : DATA_HI;
        end
      end
      RUN:     if (in_ld_restart) state_d = LEN_HI;
      default: state_d = RESET_STATE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_q               <= '0;
      wcnt_q              <= '0;
      hi_q                <= '0;
      done_q              <= (BOOT_LOAD == 0);
      err_q               <= 1'b0;
      rd_en_q             <= 1'b0;
      out_addr_misaligned <= 1'b0;
    end else begin
      rd_en_q             <= ram_re;
      out_addr_misaligned <= ram_re && in_pmem_addr[0];
      if (accept) begin
        case (state_q)
          LEN_HI:  len_q[15:8] <= in_ld_byte;
          LEN_LO:  len_q[7:0]  <= in_ld_byte;
          DATA_HI: hi_q        <= in_ld_byte;
          DATA_LO: begin
            wcnt_q <= wcnt_inc;
            if (!in_range) err_q <= 1'b1;
          end
          default: ;
        endcase
      end
      if (finish) done_q <= 1'b1;
      if (state_q == RUN && in_ld_restart) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
        wcnt_q <= '0;
      end
    end
  end

  pmem_ram #(
    .ADDR_W (AW),
    .DATA_W (PMEM_WIDTH)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (wcnt_q[AW-1:0]),
    .wdata ({hi_q, in_ld_byte}),
    .re    (ram_re),
    .raddr (in_pmem_addr[PC_WIDTH-1:1]),
    .rdata (ram_rdata)
  );

  // The read register is not reset, so gate it with a reset flop to give NOPs outside RUN.
  assign out_instr     = rd_en_q ? ram_rdata : '0;
  assign out_load_done = done_q;
  assign out_load_err  = err_q;

endmodule
